// File: rtl/ft_lockstep_recovery_if.sv
// rtl/ft_lockstep_recovery_if.sv - core compare streams and recovery outputs of the lockstep checker
interface ft_lockstep_recovery_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 8
);
  logic              c0_we_i,     c1_we_i;
  logic [ADDR_W-1:0] c0_waddr_i,  c1_waddr_i;
  logic [DATA_W-1:0] c0_wdata_i,  c1_wdata_i;
  logic              c0_retire_i, c1_retire_i;
  logic [DATA_W-1:0] c0_pc_i,     c1_pc_i;
  logic              halt_o;
  logic              error_o;
  logic [CNT_W-1:0]  err_count_o;
  logic              rst_we_o;
  logic [ADDR_W-1:0] rst_addr_o;
  logic [DATA_W-1:0] rst_data_o;
  logic              resume_o;
  logic [DATA_W-1:0] resume_pc_o;
  logic [ADDR_W-1:0] err_addr_o;
  logic [DATA_W-1:0] err_syn_o;

  modport master (
    output c0_we_i, c1_we_i, c0_waddr_i, c1_waddr_i, c0_wdata_i, c1_wdata_i,
           c0_retire_i, c1_retire_i, c0_pc_i, c1_pc_i,
    input  halt_o, error_o, err_count_o, rst_we_o, rst_addr_o, rst_data_o,
           resume_o, resume_pc_o, err_addr_o, err_syn_o
  );

  modport slave (
    input  c0_we_i, c1_we_i, c0_waddr_i, c1_waddr_i, c0_wdata_i, c1_wdata_i,
           c0_retire_i, c1_retire_i, c0_pc_i, c1_pc_i,
    output halt_o, error_o, err_count_o, rst_we_o, rst_addr_o, rst_data_o,
           resume_o, resume_pc_o, err_addr_o, err_syn_o
  );
endinterface

// File: rtl/ft_lockstep_recovery.sv
// rtl/ft_lockstep_recovery.sv - lockstep divergence detector with shadow register-file restore
// Optional divergence logging (err_addr_o/err_syn_o) enabled by defining FT_ERR_LOG_EN.
module ft_lockstep_recovery #(
  parameter int                NUM_REGS  = 32,
  parameter int                DATA_W    = 32,
  parameter int                ADDR_W    = 5,
  parameter int                CNT_W     = 8,
  parameter logic [DATA_W-1:0] BOOT_ADDR = 32'h0000_0080
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  ft_lockstep_recovery_if.slave   bus
);
  typedef enum logic [1:0] {RUN, RESTORE, RESUME} state_t;

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] idx_q;
  logic [DATA_W-1:0] shadow_q [NUM_REGS];
  logic [CNT_W-1:0]  cnt_q;
  logic [DATA_W-1:0] resume_pc_q;
  logic              error_q;
  logic              mismatch, event_det, reg_commit, pc_commit;
  logic              halt, rst_we, resume;

  always_comb begin
    mismatch = (bus.c0_we_i != bus.c1_we_i)
             | (bus.c0_we_i & bus.c1_we_i & ((bus.c0_waddr_i != bus.c1_waddr_i)
                                          | (bus.c0_wdata_i != bus.c1_wdata_i)))
             | (bus.c0_retire_i != bus.c1_retire_i)
             | (bus.c0_retire_i & bus.c1_retire_i & (bus.c0_pc_i != bus.c1_pc_i));
  end

  // Core streams only matter while running; recovery ignores them entirely.
  assign event_det  = (state_q == RUN) & mismatch;
  assign reg_commit = (state_q == RUN) & ~mismatch & bus.c0_we_i & bus.c1_we_i
                    & (bus.c0_waddr_i != '0);
  assign pc_commit  = (state_q == RUN) & ~mismatch & bus.c0_retire_i & bus.c1_retire_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= RUN;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    halt    = 1'b0;
    rst_we  = 1'b0;
    resume  = 1'b0;
    case (state_q)
      RUN:     if (mismatch) state_d = RESTORE;
      RESTORE: begin
        halt   = 1'b1;
        rst_we = 1'b1;
        if (idx_q == LAST_IDX) state_d = RESUME;
      end
      RESUME:  begin
        halt    = 1'b1;
        resume  = 1'b1;
        state_d = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      idx_q       <= '0;
      error_q     <= 1'b0;
      cnt_q       <= '0;
      resume_pc_q <= BOOT_ADDR;
      for (int i = 0; i < NUM_REGS; i++) shadow_q[i] <= '0;
    end else begin
      error_q <= event_det;
      if (event_det) begin
        idx_q <= ADDR_W'(1);
        if (cnt_q != '1) cnt_q <= cnt_q + CNT_W'(1);
      end else if (state_q == RESTORE) begin
        idx_q <= idx_q + ADDR_W'(1);
      end
      if (reg_commit) shadow_q[bus.c0_waddr_i] <= bus.c0_wdata_i;
      if (pc_commit)  resume_pc_q <= bus.c0_pc_i;
    end
  end

  assign bus.halt_o      = halt;
  assign bus.error_o     = error_q;
  assign bus.err_count_o = cnt_q;
  assign bus.rst_we_o    = rst_we;
  assign bus.rst_addr_o  = rst_we ? idx_q : '0;
  assign bus.rst_data_o  = rst_we ? shadow_q[idx_q] : '0;
  assign bus.resume_o    = resume;
  assign bus.resume_pc_o = resume_pc_q;

`ifdef FT_ERR_LOG_EN
  logic [ADDR_W-1:0] err_addr_q;
  logic [DATA_W-1:0] err_syn_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      err_addr_q <= '0;
      err_syn_q  <= '0;
    end else if (event_det) begin
      err_addr_q <= bus.c0_waddr_i;
      err_syn_q  <= bus.c0_wdata_i ^ bus.c1_wdata_i;
    end
  end

  assign bus.err_addr_o = err_addr_q;
  assign bus.err_syn_o  = err_syn_q;
`else
  assign bus.err_addr_o = '0;
  assign bus.err_syn_o  = '0;
`endif
endmodule

// File: tb/tb_ft_lockstep_recovery.sv
// tb/tb_ft_lockstep_recovery.sv - directed bench for the lockstep recovery block
module tb_ft_lockstep_recovery;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_err    = 0;

  int          halt_n, we_n, err_n, res_n, res_pos, seq_bad;
  logic [31:0] d5, d7;

  ft_lockstep_recovery_if bus ();

  ft_lockstep_recovery dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic we0, input logic [4:0] a0, input logic [31:0] d0,
                       input logic we1, input logic [4:0] a1, input logic [31:0] d1,
                       input logic rt0, input logic [31:0] p0,
                       input logic rt1, input logic [31:0] p1);
    bus.c0_we_i = we0; bus.c0_waddr_i = a0; bus.c0_wdata_i = d0;
    bus.c1_we_i = we1; bus.c1_waddr_i = a1; bus.c1_wdata_i = d1;
    bus.c0_retire_i = rt0; bus.c0_pc_i = p0;
    bus.c1_retire_i = rt1; bus.c1_pc_i = p1;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Walks a recovery sequence from the cycle error_o is expected, recording what it sees.
  task automatic observe(input bit redrive);
    halt_n = 0; we_n = 0; err_n = 0; res_n = 0; res_pos = -1; seq_bad = 0;
    d5 = 32'hFFFF_FFFF; d7 = 32'hFFFF_FFFF;
    for (int k = 0; k < 64; k++) begin
      if (!bus.halt_o) break;
      halt_n++;
      if (bus.error_o) err_n++;
      if (bus.rst_we_o) begin
        we_n++;
        if (bus.rst_addr_o != 5'(we_n)) seq_bad++;
        if (bus.rst_addr_o == 5'd5) d5 = bus.rst_data_o;
        if (bus.rst_addr_o == 5'd7) d7 = bus.rst_data_o;
      end
      if (bus.resume_o) begin
        res_n++;
        res_pos = halt_n;
      end
      if (redrive) drive(1, 3, 32'h3, 0, 0, 0, 1, 32'h999, 0, 0);
      else idle();
      step();
    end
    idle();
  endtask

  initial begin
    idle();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;

    check_val("reset_halt",      bus.halt_o,      0);
    check_val("reset_error",     bus.error_o,     0);
    check_val("reset_count",     bus.err_count_o, 0);
    check_val("reset_rst_we",    bus.rst_we_o,    0);
    check_val("reset_resume",    bus.resume_o,    0);
    check_val("reset_resume_pc", bus.resume_pc_o, 32'h80);
    check_val("reset_err_syn",   bus.err_syn_o,   0);

    // Test 1: agreed write x5 and retire 0x100; agreed x0 write is harmless.
    drive(1, 5, 32'h1234, 1, 5, 32'h1234, 1, 32'h100, 1, 32'h100);
    step();
    check_val("t1_error",     bus.error_o,     0);
    check_val("t1_halt",      bus.halt_o,      0);
    check_val("t1_resume_pc", bus.resume_pc_o, 32'h100);
    drive(1, 0, 32'hDEAD, 1, 0, 32'hDEAD, 0, 0, 0, 0);
    step();
    check_val("t1_x0_error",  bus.error_o,     0);

    // Test 2: data divergence on x5.
    drive(1, 5, 32'h1234, 1, 5, 32'h1235, 0, 0, 0, 0);
    step();
    idle();
    check_val("t2_error",    bus.error_o,     1);
    check_val("t2_rst_addr", bus.rst_addr_o,  1);
    check_val("t2_count",    bus.err_count_o, 1);
    observe(0);
    check_val("t2_halt_len", halt_n,  32);
    check_val("t2_err_n",    err_n,   1);
    check_val("t2_we_n",     we_n,    31);
    check_val("t2_addr_seq", seq_bad, 0);
    check_val("t2_res_n",    res_n,   1);
    check_val("t2_res_pos",  res_pos, 32);
    check_val("t2_shadow5",  d5,      32'h1234);
    check_val("t2_resume_pc", bus.resume_pc_o, 32'h100);
`ifdef FT_ERR_LOG_EN
    check_val("t2_err_syn",  bus.err_syn_o,  32'h1);
    check_val("t2_err_addr", bus.err_addr_o, 5);
`else
    check_val("t2_err_syn",  bus.err_syn_o,  0);
    check_val("t2_err_addr", bus.err_addr_o, 0);
`endif

    // Test 3: retire divergence while the write streams agree; nothing commits.
    drive(1, 7, 32'h7777, 1, 7, 32'h7777, 1, 32'h300, 0, 0);
    step();
    idle();
    check_val("t3_error", bus.error_o,     1);
    check_val("t3_count", bus.err_count_o, 2);
    observe(0);
    check_val("t3_shadow7",   d7, 0);
    check_val("t3_shadow5",   d5, 32'h1234);
    check_val("t3_resume_pc", bus.resume_pc_o, 32'h100);

    // Test 4: divergence on x0 data, then re-driven throughout recovery.
    drive(1, 0, 32'h1, 1, 0, 32'h2, 0, 0, 0, 0);
    step();
    observe(1);
    check_val("t4_err_n",   err_n,   1);
    check_val("t4_res_n",   res_n,   1);
    check_val("t4_halt_len", halt_n, 32);
    check_val("t4_count",   bus.err_count_o, 3);
    step();
    check_val("t4_no_rearm", bus.halt_o, 0);

    // Test 5: saturate the counter.
    for (int e = 0; e < 300; e++) begin
      drive(0, 0, 0, 1, 1, 1, 0, 0, 0, 0);
      step();
      idle();
      for (int w = 0; w < 40 && bus.halt_o; w++) step();
    end
    check_val("t5_saturate", bus.err_count_o, 255);
    check_val("t5_running",  bus.halt_o,      0);

    // Test 6: reset at restore index 10.
    drive(0, 0, 0, 0, 0, 0, 1, 32'h4, 0, 0);
    step();
    idle();
    for (int s = 0; s < 9; s++) step();
    check_val("t6_at_idx10", bus.rst_addr_o, 10);
    rst = 1'b1;
    step();
    check_val("t6_halt",      bus.halt_o,      0);
    check_val("t6_rst_we",    bus.rst_we_o,    0);
    check_val("t6_count",     bus.err_count_o, 0);
    check_val("t6_resume_pc", bus.resume_pc_o, 32'h80);
    check_val("t6_err_syn",   bus.err_syn_o,   0);
    rst = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h8);
    step();
    idle();
    observe(0);
    check_val("t6_shadow_clear", d5, 0);
    check_val("t6_halt_len",     halt_n, 32);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
